// File: rtl/minisrc_int_pkg.sv
// Shared types and constants for the Mini SRC interrupt controller.
package minisrc_int_pkg;

  localparam int          IRQ_ID_W      = 4;
  localparam logic [31:0] DEF_VEC_BASE  = 32'h0000_0100;
  localparam int          DEF_VEC_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer plus a history flop per line; reports rising edges.
module irq_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] edge_o
);

  logic [W-1:0] sync1_q, sync2_q, sync3_q;

  // Shift raw lines through the synchronizer and the edge-history stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/interrupt_ctrl.sv
// Mini SRC interrupt controller: pending/mask/IE gating, fixed priority
// (line 0 highest), and a non-nesting request/ack/iret handshake.
//
// state   | meaning
// IDLE    | no request outstanding; picks the best eligible line
// REQ     | Interrupts asserted for sel_id, waiting for int_ack
// SERVICE | handler running, waiting for iret
module interrupt_ctrl
  import minisrc_int_pkg::*;
#(
  parameter int          NUM_IRQ   = 8,
  parameter logic [31:0] VEC_BASE  = DEF_VEC_BASE,
  parameter int          VEC_SHIFT = DEF_VEC_SHIFT
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                mask_wr,
  input  logic [NUM_IRQ-1:0]  mask_data,
  input  logic                ie_set,
  input  logic                ie_clr,
  input  logic                int_ack,
  input  logic                iret,
  output logic                Interrupts,
  output logic [31:0]         int_vector,
  output logic [IRQ_ID_W-1:0] int_id,
  output logic                in_service,
  output logic [NUM_IRQ-1:0]  pending_o,
  output logic                ie_o
);

  int_state_t          state_q, state_d;
  logic [IRQ_ID_W-1:0] sel_q, sel_d, sel_next;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  mask_q, mask_d;
  logic                ie_q, ie_d;
  logic                req_q, svc_q;
  logic [NUM_IRQ-1:0]  irq_edge, eligible, clr_vec, sel_mask;
  logic [31:0]         id_ext;

  irq_sync_edge #(.W(NUM_IRQ)) u_sync (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .async_i (irq_in),
    .edge_o  (irq_edge)
  );

  assign eligible = ie_q ? (pending_q & mask_q) : '0;
  // Shifting instead of indexing keeps the 4-bit ID legal for any NUM_IRQ.
  assign sel_mask = mask_q >> sel_q;

  // Lowest set index of the eligible vector wins.
  always_comb begin
    sel_next = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_next = IRQ_ID_W'(i);
    end
  end

  // Next-state, IE, pending and mask update; a clear of IE always wins last.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    clr_vec = '0;
    ie_d    = ie_q;
    if (ie_set) ie_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          sel_d   = sel_next;
          state_d = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          clr_vec = NUM_IRQ'(1) << sel_q;
          ie_d    = 1'b0;
          state_d = SERVICE;
        end else if (!ie_q || !sel_mask[0]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (iret) begin
          ie_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ie_clr) ie_d = 1'b0;
    // A fresh edge on the line being acknowledged keeps it pending.
    pending_d = (pending_q & ~clr_vec) | irq_edge;
    mask_d    = mask_wr ? mask_data : mask_q;
  end

  // State and control registers; outputs are decoded from state_d so they are flops.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      ie_q      <= 1'b0;
      req_q     <= 1'b0;
      svc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ie_q      <= ie_d;
      req_q     <= (state_d == REQ);
      svc_q     <= (state_d == SERVICE);
    end
  end

  assign id_ext     = {{(32 - IRQ_ID_W){1'b0}}, sel_q};
  assign int_vector = req_q ? (VEC_BASE + (id_ext << VEC_SHIFT)) : 32'h0;
  assign Interrupts = req_q;
  assign in_service = svc_q;
  assign int_id     = sel_q;
  assign pending_o  = pending_q;
  assign ie_o       = ie_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Scenario bench for interrupt_ctrl; expected requests are queued when the
// lines are raised and popped when Interrupts asserts.
module tb_interrupt_ctrl;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] vec;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  irq_in = '0;
  logic        mask_wr = 1'b0;
  logic [7:0]  mask_data = '0;
  logic        ie_set = 1'b0, ie_clr = 1'b0, int_ack = 1'b0, iret = 1'b0;
  logic        Interrupts;
  logic [31:0] int_vector;
  logic [3:0]  int_id;
  logic        in_service;
  logic [7:0]  pending_o;
  logic        ie_o;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  interrupt_ctrl #(.NUM_IRQ(8), .VEC_BASE(32'h0000_0100), .VEC_SHIFT(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .irq_in     (irq_in),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .ie_set     (ie_set),
    .ie_clr     (ie_clr),
    .int_ack    (int_ack),
    .iret       (iret),
    .Interrupts (Interrupts),
    .int_vector (int_vector),
    .int_id     (int_id),
    .in_service (in_service),
    .pending_o  (pending_o),
    .ie_o       (ie_o)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // lat = number of clock edges until Interrupts is seen high, -1 on timeout.
  task automatic wait_req(input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (Interrupts === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    irq_in = '0; mask_wr = 0; ie_set = 0; ie_clr = 0; int_ack = 0; iret = 0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({Interrupts, in_service, ie_o} !== 3'b000 || int_vector !== 32'h0 ||
        int_id !== 4'h0 || pending_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got irq=%b svc=%b ie=%b vec=%h id=%h pend=%h want all 0",
               Interrupts, in_service, ie_o, int_vector, int_id, pending_o);
    end
    do_reset();
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    mask_data = 8'hFF; mask_wr = 1; ie_set = 1;
    tick();
    mask_wr = 0; ie_set = 0;
    checks++;
    if (ie_o !== 1'b1) begin errors++; $display("FAIL basic_ie got %b want 1", ie_o); end
    irq_in[3] = 1'b1;
    sb.push_back('{id: 4'd3, vec: 32'h130});
    wait_req(10, lat);
    // Edges counted from the first sampling edge E0: high after E3 is the 4th edge.
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL basic_sb got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      if (int_id !== e.id || int_vector !== e.vec) begin
        errors++;
        $display("FAIL basic_req got id=%h vec=%h want id=%h vec=%h", int_id, int_vector, e.id, e.vec);
      end
    end
    int_ack = 1; tick(); int_ack = 0;
    checks++;
    if ({Interrupts, in_service, pending_o[3], ie_o} !== 4'b0100) begin
      errors++;
      $display("FAIL basic_ack got irq=%b svc=%b pend3=%b ie=%b want 0 1 0 0",
               Interrupts, in_service, pending_o[3], ie_o);
    end
    iret = 1; tick(); iret = 0;
    checks++;
    if (in_service !== 1'b0 || ie_o !== 1'b1) begin
      errors++; $display("FAIL basic_iret got svc=%b ie=%b want 0 1", in_service, ie_o);
    end
    irq_in[3] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_priority();
    exp_t e;
    int   lat;
    irq_in[5] = 1'b1; irq_in[2] = 1'b1;
    sb.push_back('{id: 4'd2, vec: 32'h120});
    sb.push_back('{id: 4'd5, vec: 32'h150});
    wait_req(10, lat);
    checks++;
    if (lat < 0) begin errors++; $display("FAIL prio_timeout got no request want request"); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL prio_sb1 got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      if (int_id !== e.id || int_vector !== e.vec) begin
        errors++;
        $display("FAIL prio_first got id=%h vec=%h want id=%h vec=%h", int_id, int_vector, e.id, e.vec);
      end
    end
    int_ack = 1; tick(); int_ack = 0;
    iret = 1; tick(); iret = 0;
    checks++;
    if (Interrupts !== 1'b0) begin errors++; $display("FAIL prio_after_iret got %b want 0", Interrupts); end
    tick();
    checks++;
    if (Interrupts !== 1'b1) begin errors++; $display("FAIL prio_reassert got %b want 1", Interrupts); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL prio_sb2 got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      if (int_id !== e.id || int_vector !== e.vec) begin
        errors++;
        $display("FAIL prio_second got id=%h vec=%h want id=%h vec=%h", int_id, int_vector, e.id, e.vec);
      end
    end
    int_ack = 1; tick(); int_ack = 0;
    iret = 1; tick(); iret = 0;
    irq_in = '0;
    repeat (3) tick();
  endtask

  task automatic test_gating();
    exp_t e;
    int   lat;
    do_reset();
    mask_data = 8'h00; mask_wr = 1; ie_set = 1;
    tick();
    mask_wr = 0; ie_set = 0;
    irq_in[1] = 1'b1;
    repeat (4) tick();
    checks++;
    if (pending_o !== 8'h02 || Interrupts !== 1'b0 || int_vector !== 32'h0) begin
      errors++;
      $display("FAIL gate_masked got pend=%h irq=%b vec=%h want 02 0 0", pending_o, Interrupts, int_vector);
    end
    sb.push_back('{id: 4'd1, vec: 32'h110});
    mask_data = 8'h02; mask_wr = 1;
    tick();
    mask_wr = 0;
    wait_req(5, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL gate_unmask_latency got %0d want 1", lat); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL gate_sb got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      if (int_id !== e.id || int_vector !== e.vec) begin
        errors++;
        $display("FAIL gate_req got id=%h vec=%h want id=%h vec=%h", int_id, int_vector, e.id, e.vec);
      end
    end
    ie_clr = 1; tick(); ie_clr = 0;
    checks++;
    if (ie_o !== 1'b0 || Interrupts !== 1'b1) begin
      errors++; $display("FAIL gate_ieclr got ie=%b irq=%b want 0 1", ie_o, Interrupts);
    end
    tick();
    checks++;
    if (Interrupts !== 1'b0 || pending_o !== 8'h02) begin
      errors++; $display("FAIL gate_withdraw got irq=%b pend=%h want 0 02", Interrupts, pending_o);
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    int   lat;
    do_reset();
    mask_data = 8'hFF; mask_wr = 1; ie_set = 1;
    tick();
    mask_wr = 0; ie_set = 0;
    irq_in[4] = 1'b1;
    sb.push_back('{id: 4'd4, vec: 32'h140});
    wait_req(10, lat);
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL same_sb1 got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      if (int_id !== e.id || int_vector !== e.vec) begin
        errors++;
        $display("FAIL same_first got id=%h vec=%h want id=%h vec=%h", int_id, int_vector, e.id, e.vec);
      end
    end
    irq_in[4] = 1'b0;
    repeat (3) tick();
    irq_in[4] = 1'b1;
    tick();
    tick();
    int_ack = 1; tick(); int_ack = 0;
    checks++;
    if (pending_o[4] !== 1'b1 || in_service !== 1'b1) begin
      errors++; $display("FAIL same_set_wins got pend4=%b svc=%b want 1 1", pending_o[4], in_service);
    end
    sb.push_back('{id: 4'd4, vec: 32'h140});
    iret = 1; tick(); iret = 0;
    wait_req(5, lat);
    checks++;
    if (sb.size() == 0 || lat < 0) begin
      errors++; $display("FAIL same_second got lat=%0d queue=%0d want request", lat, sb.size());
    end else begin
      e = sb.pop_front();
      if (int_id !== e.id || int_vector !== e.vec) begin
        errors++;
        $display("FAIL same_second_req got id=%h vec=%h want id=%h vec=%h", int_id, int_vector, e.id, e.vec);
      end
    end
  endtask

  task automatic test_reset_service();
    exp_t e;
    int   lat;
    int_ack = 1; tick(); int_ack = 0;
    irq_in[6] = 1'b1;
    repeat (3) tick();
    checks++;
    if (pending_o[6] !== 1'b1 || in_service !== 1'b1) begin
      errors++; $display("FAIL rst_pre got pend6=%b svc=%b want 1 1", pending_o[6], in_service);
    end
    @(posedge Clock);
    #4 Reset = 1'b1;
    irq_in = '0;
    #1;
    checks++;
    if ({Interrupts, in_service, ie_o} !== 3'b000 || int_vector !== 32'h0 ||
        int_id !== 4'h0 || pending_o !== 8'h00) begin
      errors++;
      $display("FAIL rst_async got irq=%b svc=%b ie=%b vec=%h id=%h pend=%h want all 0",
               Interrupts, in_service, ie_o, int_vector, int_id, pending_o);
    end
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    mask_data = 8'hFF; mask_wr = 1;
    tick();
    mask_wr = 0;
    repeat (4) tick();
    checks++;
    if (Interrupts !== 1'b0 || pending_o !== 8'h00) begin
      errors++; $display("FAIL rst_quiet got irq=%b pend=%h want 0 00", Interrupts, pending_o);
    end
    irq_in[7] = 1'b1;
    repeat (4) tick();
    checks++;
    if (Interrupts !== 1'b0 || pending_o !== 8'h80) begin
      errors++; $display("FAIL rst_ie_off got irq=%b pend=%h want 0 80", Interrupts, pending_o);
    end
    sb.push_back('{id: 4'd7, vec: 32'h170});
    ie_set = 1; tick(); ie_set = 0;
    wait_req(5, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL rst_reenable_latency got %0d want 1", lat); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL rst_sb got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      if (int_id !== e.id || int_vector !== e.vec) begin
        errors++;
        $display("FAIL rst_req got id=%h vec=%h want id=%h vec=%h", int_id, int_vector, e.id, e.vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_gating();
    test_same_cycle();
    test_reset_service();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Interrupt controller for the Mini SRC CPU. It synchronizes and edge-detects external interrupt lines and holds them in a pending register gated by a mask and a global enable. It selects the highest-priority request and drives the single `Interrupts` request into the ControlUnit, handing over a stable vector and ID. Return-from-interrupt is handled through a request/acknowledge/return handshake; there is no nesting.

## Interface
- NUM_IRQ, 8, number of external interrupt lines (1..16); index 0 is the highest priority.
- VEC_BASE, 32'h0000_0100, address of the vector for ID 0.
- VEC_SHIFT, 4, log2 of the spacing between vectors in bytes.
- Clock  in  1  single system clock; all state is on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- irq_in  in  NUM_IRQ  external interrupt lines, asynchronous; an event is a rising edge.
- mask_wr  in  1  one-cycle pulse that loads `mask_data` into the mask register.
- mask_data  in  NUM_IRQ  new mask; 1 enables the line.
- ie_set  in  1  pulse that sets the global enable IE (`ei` instruction).
- ie_clr  in  1  pulse that clears IE (`di` instruction).
- int_ack  in  1  ControlUnit pulse when it enters the interrupt entry sequence.
- iret  in  1  ControlUnit pulse when it executes return-from-interrupt.
- Interrupts  out  1  request to the ControlUnit.
- int_vector  out  32  handler address, valid while `Interrupts`=1.
- int_id  out  4  ID of the selected line, valid while `Interrupts`=1 or `in_service`=1.
- in_service  out  1  a handler is active.
- pending_o  out  NUM_IRQ  pending register, for status readback.
- ie_o  out  1  current IE.

## Operation
- Per line: 2-flop synchronizer, then a third flop for edge detection. Edge = sync2 & ~sync3.
- An edge sets `pending[i]` regardless of mask or IE. Masked events stay latched.
- `eligible` = pending & mask when IE=1, else 0.
- FSM states are IDLE, REQ and SERVICE.
- IDLE:
  - If `eligible`≠0, latch `sel_id` = lowest set index of `eligible` and go to REQ.
- REQ:
  - `Interrupts`=1.
  - On `int_ack`: clear `pending[sel_id]`, clear IE, go to SERVICE.
  - Else, if IE=0 or `mask[sel_id]`=0 (evaluated on the registered values): withdraw and return to IDLE. IDLE reselects on the next cycle.
  - Otherwise `sel_id` stays fixed. A higher-priority arrival does not preempt it.
- SERVICE:
  - `in_service`=1.
  - On `iret`: set IE=1, go to IDLE.
  - Edges arriving during SERVICE stay pending.
- `int_vector` = VEC_BASE + (sel_id << VEC_SHIFT), modulo 2^32. Driven as 0 when `Interrupts`=0.
- Simultaneous events:
  - `ie_set` and `ie_clr` together: clear wins.
  - `ie_set` in SERVICE: IE=1, but the state stays SERVICE (no nesting).
  - New edge on `sel_id` in the same cycle as `int_ack`: set wins and the bit remains pending.
  - `int_ack` outside REQ is ignored. `iret` outside SERVICE is ignored.
  - `iret` and `ie_clr` in the same cycle: IE ends at 0.
- `mask_wr` takes effect at the next edge. A new edge and a mask write in the same cycle both apply.
- Reset (asynchronous, including mid-handler): state=IDLE; pending, mask, IE and sync flops all 0; every output 0.

## Timing
- An `irq_in` rise first sampled at edge E0 sets pending at E2 and enters REQ at E3. `Interrupts` is registered and is high after E3.
- Pulses shorter than one clock period may be lost; this is the documented limit.
- `int_ack` sampled at edge N: `Interrupts`=0 and `in_service`=1 after N, and IE=0 after N.
- `iret` sampled at edge N: IDLE and IE=1 after N. A pending eligible request reasserts `Interrupts` after N+1.
- All outputs are registered except `int_vector`, which is combinational from `sel_id` and state.

## Structure
- Package `minisrc_int_pkg` holds:
  - the FSM state enum `int_state_t` {IDLE, REQ, SERVICE};
  - the default vector constants;
  - the `IRQ_ID_W`=4 constant.
- Sub-module `irq_sync_edge`: one NUM_IRQ-wide instance containing the 3-flop chain and producing the edge vector.
- Priority encoder and FSM live in `interrupt_ctrl`.

## Test plan
- Basic request: reset, mask=8'hFF, `ie_set`, raise `irq_in[3]` → `Interrupts` high 3 edges after the first sampling edge, `int_vector`=32'h130, `int_id`=3. Then `int_ack` → `in_service`=1, `pending_o[3]`=0, `ie_o`=0.
- Priority: lines 5 and 2 rise in the same cycle → `int_id`=2. After ack and `iret` → `int_id`=5, `int_vector`=32'h150.
- Gating: mask=8'h00, line 1 rises → `pending_o`=8'h02 with `Interrupts`=0. Write mask=8'h02 → `Interrupts` rises. `ie_clr` while in REQ → `Interrupts` drops the next cycle, pending is still 8'h02.
- Same-cycle set and clear: edge on line 4 coincident with `int_ack` for ID 4 → `pending_o[4]`=1 after the ack. `iret` → a second request with `int_id`=4.
- Reset during SERVICE: assert `Reset` asynchronously, mid-cycle → all outputs 0 immediately; after release, `Interrupts` stays 0 until new edges arrive and IE is re-enabled.
